// File: rtl/axi4_burst_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_slave_mem
// Description : AXI4 burst memory slave with independent write and read
//               engines (one outstanding transaction each) over a word RAM.
//               FIXED and INCR bursts are always legal. WRAP is legal only
//               when AXI_SLV_WRAP_EN is defined; otherwise it is treated as
//               a reserved burst.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_burst_slave_mem #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 512
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int c_strb_w = DATA_WIDTH / 8;
  localparam int c_sz     = $clog2(c_strb_w);
  localparam int c_idx_w  = ADDR_WIDTH - c_sz;
  localparam int c_mem_aw = $clog2(MEM_DEPTH);
  localparam logic [c_idx_w:0] c_depth = (c_idx_w + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte-offset address bits carry no information for full-width transfers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, S_AXI_AWADDR[c_sz-1:0], S_AXI_ARADDR[c_sz-1:0]};

  // ---------------------------------------------------------------- write --
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  w_state_t           w_state_q, w_state_d;
  logic [c_idx_w-1:0] w_idx_q, w_idx_nxt;
  logic [7:0]         w_len_q, w_cnt_q;
  logic [1:0]         w_burst_q;
  logic               w_ok_q, w_err_q;
  logic               w_aw_hs, w_w_hs, w_last_beat, w_in_range, w_aw_legal;

  assign S_AXI_AWREADY = (w_state_q == W_IDLE) && !ARESET;
  assign S_AXI_WREADY  = (w_state_q == W_DATA);
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = (S_AXI_BVALID && w_err_q) ? 2'b10 : 2'b00;

  assign w_aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_in_range  = ({1'b0, w_idx_q} < c_depth);

  // Burst legality of the incoming write address.
  always_comb begin
    w_aw_legal = (S_AXI_AWBURST == 2'b00) || (S_AXI_AWBURST == 2'b01);
`ifdef AXI_SLV_WRAP_EN
    if (S_AXI_AWBURST == 2'b10)
      w_aw_legal = (S_AXI_AWLEN == 8'd1) || (S_AXI_AWLEN == 8'd3) ||
                   (S_AXI_AWLEN == 8'd7) || (S_AXI_AWLEN == 8'd15);
`endif
  end

  // Next write word index; INCR wraps naturally at the index width.
  always_comb begin
    w_idx_nxt = w_idx_q;
    if (w_burst_q == 2'b01) begin
      w_idx_nxt = w_idx_q + c_idx_w'(1);
    end
`ifdef AXI_SLV_WRAP_EN
    else if (w_burst_q == 2'b10) begin
      w_idx_nxt = (w_idx_q & ~c_idx_w'(w_len_q)) |
                  ((w_idx_q + c_idx_w'(1)) & c_idx_w'(w_len_q));
    end
`endif
  end

  // Write state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  // Write next-state: exactly len+1 beats are taken regardless of WLAST.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (w_aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_w_hs && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write burst context: address, beat count and sticky error.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_ok_q    <= 1'b0;
      w_err_q   <= 1'b0;
    end else if (w_aw_hs) begin
      w_idx_q   <= S_AXI_AWADDR[ADDR_WIDTH-1:c_sz];
      w_len_q   <= S_AXI_AWLEN;
      w_burst_q <= S_AXI_AWBURST;
      w_cnt_q   <= '0;
      w_ok_q    <= w_aw_legal;
      w_err_q   <= !w_aw_legal;
    end else if (w_w_hs) begin
      w_idx_q <= w_idx_nxt;
      w_cnt_q <= w_cnt_q + 8'd1;
      if (!w_in_range || (S_AXI_WLAST != w_last_beat)) w_err_q <= 1'b1;
    end
  end

  // RAM byte-enabled write; suppressed for illegal bursts and out-of-range words.
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_w_hs && w_ok_q && w_in_range) begin
      for (int b = 0; b < c_strb_w; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_idx_q[c_mem_aw-1:0]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read --
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOAD = 2'd1, R_DATA = 2'd2} r_state_t;
  r_state_t            r_state_q, r_state_d;
  logic [c_idx_w-1:0]  r_idx_q, r_idx_nxt, r_ld_idx;
  logic [7:0]          r_len_q, r_cnt_q, r_ld_cnt;
  logic [1:0]          r_burst_q, r_resp_q;
  logic                r_ok_q, r_last_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic                r_ar_hs, r_ar_legal, r_ld_en, r_ld_in_range;

  assign S_AXI_ARREADY = (r_state_q == R_IDLE) && !ARESET;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = r_resp_q;
  assign S_AXI_RLAST   = r_last_q && S_AXI_RVALID;

  assign r_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  // A beat is fetched once after AR, then on every accepted non-final beat.
  assign r_ld_en       = (r_state_q == R_LOAD) ||
                         ((r_state_q == R_DATA) && S_AXI_RREADY && !r_last_q);
  assign r_ld_idx      = (r_state_q == R_LOAD) ? r_idx_q : r_idx_nxt;
  assign r_ld_cnt      = (r_state_q == R_LOAD) ? r_cnt_q : r_cnt_q + 8'd1;
  assign r_ld_in_range = ({1'b0, r_ld_idx} < c_depth);

  // Burst legality of the incoming read address.
  always_comb begin
    r_ar_legal = (S_AXI_ARBURST == 2'b00) || (S_AXI_ARBURST == 2'b01);
`ifdef AXI_SLV_WRAP_EN
    if (S_AXI_ARBURST == 2'b10)
      r_ar_legal = (S_AXI_ARLEN == 8'd1) || (S_AXI_ARLEN == 8'd3) ||
                   (S_AXI_ARLEN == 8'd7) || (S_AXI_ARLEN == 8'd15);
`endif
  end

  // Next read word index.
  always_comb begin
    r_idx_nxt = r_idx_q;
    if (r_burst_q == 2'b01) begin
      r_idx_nxt = r_idx_q + c_idx_w'(1);
    end
`ifdef AXI_SLV_WRAP_EN
    else if (r_burst_q == 2'b10) begin
      r_idx_nxt = (r_idx_q & ~c_idx_w'(r_len_q)) |
                  ((r_idx_q + c_idx_w'(1)) & c_idx_w'(r_len_q));
    end
`endif
  end

  // Read state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  // Read next-state: one fetch cycle after AR, then stream until RLAST accepted.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (r_ar_hs) r_state_d = R_LOAD;
      R_LOAD:  r_state_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY && r_last_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read context and output beat register; held while the master stalls.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_ok_q    <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= 2'b00;
    end else if (r_ar_hs) begin
      r_idx_q   <= S_AXI_ARADDR[ADDR_WIDTH-1:c_sz];
      r_len_q   <= S_AXI_ARLEN;
      r_burst_q <= S_AXI_ARBURST;
      r_cnt_q   <= '0;
      r_ok_q    <= r_ar_legal;
    end else if (r_ld_en) begin
      r_idx_q  <= r_ld_idx;
      r_cnt_q  <= r_ld_cnt;
      r_last_q <= (r_ld_cnt == r_len_q);
      if (r_ok_q && r_ld_in_range) begin
        r_data_q <= mem[r_ld_idx[c_mem_aw-1:0]];
        r_resp_q <= 2'b00;
      end else begin
        r_data_q <= '0;
        r_resp_q <= 2'b10;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_burst_slave_mem
// Description : Directed self-checking bench for axi4_burst_slave_mem.
//               Follows AXI_SLV_WRAP_EN for the WRAP expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [11:0] S_AXI_AWADDR = '0;
  logic [7:0]  S_AXI_AWLEN = '0;
  logic [1:0]  S_AXI_AWBURST = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WLAST = 1'b0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [11:0] S_AXI_ARADDR = '0;
  logic [7:0]  S_AXI_ARLEN = '0;
  logic [1:0]  S_AXI_ARBURST = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;

  axi4_burst_slave_mem #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(512)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd_v [0:15];
  logic [31:0] rd_v [0:15];
  logic [1:0]  rr_v [0:15];
  logic [15:0] rl_mask;
  int          rbeats, rlat, rstab;
  logic [1:0]  bresp;
  logic        bimm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int last_at);
    int t;
    S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
    t = 0;
    while (!S_AXI_AWREADY && t < 50) begin step(); t++; end
    if (t >= 50) check("aw_timeout", 32'd0, 32'd1);
    step();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      S_AXI_WDATA = wd_v[i]; S_AXI_WSTRB = strb; S_AXI_WLAST = (i == last_at); S_AXI_WVALID = 1'b1;
      t = 0;
      while (!S_AXI_WREADY && t < 50) begin step(); t++; end
      if (t >= 50) check("w_timeout", 32'd0, 32'd1);
      step();
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    bimm = S_AXI_BVALID;
    t = 0;
    while (!S_AXI_BVALID && t < 50) begin step(); t++; end
    if (t >= 50) check("b_timeout", 32'd0, 32'd1);
    bresp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
  endtask

  // pat bit k gives RREADY in the k-th cycle of the data phase (repeats every 16).
  task automatic do_read(input logic [11:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [15:0] pat);
    int t, cyc, beat;
    logic hp, pl;
    logic [31:0] pd;
    logic [1:0] pr;
    rl_mask = '0; rstab = 0; hp = 1'b0; pd = '0; pr = '0; pl = 1'b0;
    for (int i = 0; i < 16; i++) begin rd_v[i] = '0; rr_v[i] = 2'b11; end
    S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!S_AXI_ARREADY && t < 50) begin step(); t++; end
    if (t >= 50) check("ar_timeout", 32'd0, 32'd1);
    step();
    S_AXI_ARVALID = 1'b0;
    rlat = 1;
    while (!S_AXI_RVALID && rlat < 20) begin step(); rlat++; end
    if (rlat >= 20) check("r_timeout", 32'd0, 32'd1);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      S_AXI_RREADY = pat[cyc % 16];
      if (S_AXI_RVALID) begin
        if (hp && (pd !== S_AXI_RDATA || pr !== S_AXI_RRESP || pl !== S_AXI_RLAST)) rstab++;
        if (S_AXI_RREADY) begin
          rd_v[beat] = S_AXI_RDATA; rr_v[beat] = S_AXI_RRESP; rl_mask[beat] = S_AXI_RLAST;
          beat++; hp = 1'b0;
        end else begin
          pd = S_AXI_RDATA; pr = S_AXI_RRESP; pl = S_AXI_RLAST; hp = 1'b1;
        end
      end
      step();
      cyc++;
    end
    if (cyc >= 200) check("r_beat_timeout", 32'd0, 32'd1);
    S_AXI_RREADY = 1'b0;
    rbeats = beat;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset
    repeat (3) step();
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_wready",  32'(S_AXI_WREADY),  32'd0);
    check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
    check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    check("rst_rdata",   S_AXI_RDATA,        32'd0);
    ARESET = 1'b0;
    #1;
    check("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    check("post_rst_arready", 32'(S_AXI_ARREADY), 32'd1);
    step();

    // ---- 1: INCR write/readback
    wd_v[0] = 32'h11; wd_v[1] = 32'h22; wd_v[2] = 32'h33; wd_v[3] = 32'h44;
    do_write(12'h010, 8'd3, 2'b01, 4'hF, 3);
    check("t1_bresp", 32'(bresp), 32'd0);
    check("t1_b_timing", 32'(bimm), 32'd1);
    check("t1_b_done", 32'(S_AXI_BVALID), 32'd0);
    do_read(12'h010, 8'd3, 2'b01, 16'hFFFF);
    check("t1_rlat", 32'(rlat), 32'd2);
    check("t1_beats", 32'(rbeats), 32'd4);
    check("t1_d0", rd_v[0], 32'h11);
    check("t1_d1", rd_v[1], 32'h22);
    check("t1_d2", rd_v[2], 32'h33);
    check("t1_d3", rd_v[3], 32'h44);
    check("t1_rresp", 32'({rr_v[0], rr_v[1], rr_v[2], rr_v[3]}), 32'd0);
    check("t1_rlast", 32'(rl_mask), 32'h0008);
    check("t1_r_idle", 32'(S_AXI_RVALID), 32'd0);

    // ---- 2: byte strobes, then FIXED read
    wd_v[0] = 32'h12345678;
    do_write(12'h020, 8'd0, 2'b01, 4'hF, 0);
    wd_v[0] = 32'hAABBCCDD;
    do_write(12'h020, 8'd0, 2'b01, 4'b0011, 0);
    check("t2_bresp", 32'(bresp), 32'd0);
    do_read(12'h020, 8'd0, 2'b01, 16'hFFFF);
    check("t2_strb_data", rd_v[0], 32'h1234CCDD);
    check("t2_rlast", 32'(rl_mask), 32'h0001);
    do_read(12'h020, 8'd1, 2'b00, 16'hFFFF);
    check("t2_fixed_d0", rd_v[0], 32'h1234CCDD);
    check("t2_fixed_d1", rd_v[1], 32'h1234CCDD);
    check("t2_fixed_rlast", 32'(rl_mask), 32'h0002);

    // ---- 3: 8-beat read with RREADY stalls
    for (int i = 0; i < 8; i++) wd_v[i] = 32'h100 + 32'(i) * 32'h11;
    do_write(12'h040, 8'd7, 2'b01, 4'hF, 7);
    check("t3_bresp", 32'(bresp), 32'd0);
    do_read(12'h040, 8'd7, 2'b01, 16'b1001_1010_0110_1001);
    check("t3_beats", 32'(rbeats), 32'd8);
    check("t3_stable", 32'(rstab), 32'd0);
    check("t3_rlast", 32'(rl_mask), 32'h0080);
    for (int i = 0; i < 8; i++) check("t3_data", rd_v[i], 32'h100 + 32'(i) * 32'h11);
    check("t3_r_idle", 32'(S_AXI_RVALID), 32'd0);

    // ---- 4: out-of-range word and misplaced WLAST
    wd_v[0] = 32'hDEADBEEF;
    do_write(12'h000, 8'd0, 2'b01, 4'hF, 0);
    wd_v[0] = 32'h00000055;
    do_write(12'h800, 8'd0, 2'b01, 4'hF, 0);
    check("t4_oor_bresp", 32'(bresp), 32'd2);
    do_read(12'h000, 8'd0, 2'b01, 16'hFFFF);
    check("t4_no_alias", rd_v[0], 32'hDEADBEEF);
    do_read(12'h800, 8'd0, 2'b01, 16'hFFFF);
    check("t4_oor_rdata", rd_v[0], 32'd0);
    check("t4_oor_rresp", 32'(rr_v[0]), 32'd2);
    do_read(12'h7FC, 8'd1, 2'b01, 16'hFFFF);
    check("t4_edge_rresp0", 32'(rr_v[0]), 32'd0);
    check("t4_edge_rresp1", 32'(rr_v[1]), 32'd2);
    check("t4_edge_rdata1", rd_v[1], 32'd0);
    wd_v[0] = 32'h61; wd_v[1] = 32'h62; wd_v[2] = 32'h63; wd_v[3] = 32'h64;
    do_write(12'h060, 8'd3, 2'b01, 4'hF, 1);
    check("t4_wlast_bresp", 32'(bresp), 32'd2);
    check("t4_wlast_4beats", 32'(bimm), 32'd1);
    do_read(12'h060, 8'd3, 2'b01, 16'hFFFF);
    check("t4_wlast_d0", rd_v[0], 32'h61);
    check("t4_wlast_d3", rd_v[3], 32'h64);

    // ---- reserved burst
    wd_v[0] = 32'h99;
    do_write(12'h014, 8'd0, 2'b11, 4'hF, 0);
    check("rsv_bresp", 32'(bresp), 32'd2);
    do_read(12'h014, 8'd0, 2'b01, 16'hFFFF);
    check("rsv_no_write", rd_v[0], 32'h22);
    do_read(12'h010, 8'd0, 2'b11, 16'hFFFF);
    check("rsv_rdata", rd_v[0], 32'd0);
    check("rsv_rresp", 32'(rr_v[0]), 32'd2);

    // ---- 5: WRAP
    wd_v[0] = 32'hA0; wd_v[1] = 32'hA1; wd_v[2] = 32'hA2; wd_v[3] = 32'hA3;
    do_write(12'h018, 8'd3, 2'b10, 4'hF, 3);
`ifdef AXI_SLV_WRAP_EN
    check("t5_bresp", 32'(bresp), 32'd0);
    do_read(12'h010, 8'd3, 2'b01, 16'hFFFF);
    check("t5_w010", rd_v[0], 32'hA2);
    check("t5_w014", rd_v[1], 32'hA3);
    check("t5_w018", rd_v[2], 32'hA0);
    check("t5_w01c", rd_v[3], 32'hA1);
    do_read(12'h018, 8'd3, 2'b10, 16'hFFFF);
    check("t5_rwrap_d2", rd_v[2], 32'hA2);
    check("t5_rwrap_rresp", 32'(rr_v[3]), 32'd0);
`else
    check("t5_bresp", 32'(bresp), 32'd2);
    do_read(12'h010, 8'd3, 2'b01, 16'hFFFF);
    check("t5_w010", rd_v[0], 32'h11);
    check("t5_w014", rd_v[1], 32'h22);
    check("t5_w018", rd_v[2], 32'h33);
    check("t5_w01c", rd_v[3], 32'h44);
    do_read(12'h018, 8'd3, 2'b10, 16'hFFFF);
    check("t5_rwrap_d0", rd_v[0], 32'd0);
    check("t5_rwrap_rresp", 32'(rr_v[3]), 32'd2);
    check("t5_rwrap_rlast", 32'(rl_mask), 32'h0008);
`endif

    // ---- 6: reset in the middle of an 8-beat write
    for (int i = 0; i < 8; i++) wd_v[i] = 32'hC0 + 32'(i);
    S_AXI_AWADDR = 12'h080; S_AXI_AWLEN = 8'd7; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
    check("t6_awready", 32'(S_AXI_AWREADY), 32'd1);
    step();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      S_AXI_WDATA = wd_v[i]; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
      check("t6_wready", 32'(S_AXI_WREADY), 32'd1);
      step();
    end
    S_AXI_WVALID = 1'b0;
    step();
    ARESET = 1'b1;
    #1;
    check("t6_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("t6_rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    step();
    ARESET = 1'b0;
    #1;
    check("t6_post_awready", 32'(S_AXI_AWREADY), 32'd1);
    check("t6_post_wready", 32'(S_AXI_WREADY), 32'd0);
    step();
    check("t6_post_bvalid", 32'(S_AXI_BVALID), 32'd0);
    do_read(12'h080, 8'd2, 2'b01, 16'hFFFF);
    check("t6_d0", rd_v[0], 32'hC0);
    check("t6_d1", rd_v[1], 32'hC1);
    check("t6_d2", rd_v[2], 32'hC2);
    wd_v[0] = 32'h0BADF00D;
    do_write(12'h0A0, 8'd0, 2'b01, 4'hF, 0);
    check("t6_recover_bresp", 32'(bresp), 32'd0);
    check("t6_recover_b_timing", 32'(bimm), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
